// File: rtl/mc_control_unit.sv
// Multi-cycle control unit for the MIPS subset. It sequences FETCH/DECODE/EXEC/MEM/WB with
// req/ack memory handshakes, and traps on an ack timeout or an undefined instruction.
module mc_control_unit #(
   parameter int BE_W        = 4,
   parameter int MEM_TIMEOUT = 255,
   parameter int CNT_W       = 8
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [31:0]     instr,
   input  logic            alu_zero,
   input  logic            imem_ack,
   input  logic            dmem_ack,
   output logic            imem_req,
   output logic            ir_load,
   output logic            dmem_req,
   output logic [BE_W-1:0] dmem_be,
   output logic            reg_wren,
   output logic            dmux_sel,
   output logic            rmux_sel,
   output logic            alu_src_sel,
   output logic [3:0]      alu_ctrl,
   output logic            pc_en,
   output logic [1:0]      pc_sel,
   output logic            retire,
   output logic            illegal,
   output logic            bus_err
);
   localparam logic [2:0] ST_FETCH  = 3'd0;
   localparam logic [2:0] ST_DECODE = 3'd1;
   localparam logic [2:0] ST_EXEC   = 3'd2;
   localparam logic [2:0] ST_MEM    = 3'd3;
   localparam logic [2:0] ST_WB     = 3'd4;
   localparam logic [2:0] ST_TRAP   = 3'd5;

   localparam logic [5:0] OP_RTYPE = 6'h00, OP_J    = 6'h02, OP_BEQ  = 6'h04, OP_BNE  = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08, OP_ADDIU = 6'h09, OP_SLTI = 6'h0A, OP_ANDI = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D, OP_LUI  = 6'h0F, OP_LW   = 6'h23, OP_SB   = 6'h28;
   localparam logic [5:0] OP_SH    = 6'h29, OP_SW   = 6'h2B;

   localparam logic [5:0] FN_SLL = 6'h00, FN_SRL = 6'h02, FN_SRA = 6'h03, FN_JR  = 6'h08;
   localparam logic [5:0] FN_ADD = 6'h20, FN_ADDU = 6'h21, FN_SUB = 6'h22, FN_SUBU = 6'h23;
   localparam logic [5:0] FN_AND = 6'h24, FN_OR  = 6'h25, FN_XOR = 6'h26, FN_NOR = 6'h27;
   localparam logic [5:0] FN_SLT = 6'h2A;

   localparam logic [3:0] ALU_AND = 4'b0000, ALU_OR  = 4'b0001, ALU_XOR  = 4'b0010, ALU_NOR = 4'b0011;
   localparam logic [3:0] ALU_ADDU = 4'b0100, ALU_ADD = 4'b0101, ALU_SUBU = 4'b0110, ALU_SUB = 4'b0111;
   localparam logic [3:0] ALU_SLT = 4'b1000, ALU_SLL = 4'b1001, ALU_SRL  = 4'b1010, ALU_SRA = 4'b1011;

   localparam logic [CNT_W-1:0] TIMEOUT_C    = CNT_W'(MEM_TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_ONE_C    = CNT_W'(1'b1);
   localparam bit               TIMEOUT_EN_C = (MEM_TIMEOUT != 32'sd0);
   localparam logic [BE_W-1:0]  BE_BYTE_C    = BE_W'(1'b1);
   localparam logic [BE_W-1:0]  BE_HALF_C    = BE_W'(2'b11);
   localparam logic [BE_W-1:0]  BE_WORD_C    = {BE_W{1'b1}};

   logic [2:0]       state_r, state_nxt_s;
   logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
   logic             illegal_r, illegal_nxt_s, bus_err_r, bus_err_nxt_s;
   logic [5:0]       opcode_s, funct_s;
   logic             legal_s, is_ralu_s, is_jr_s, is_j_s, is_branch_s, is_beq_s;
   logic             is_load_s, is_store_s, is_lui_s, branch_taken_s, steer_s;
   logic [3:0]       alu_op_s;
   logic [BE_W-1:0]  store_be_s, dmem_be_s;
   logic             imem_req_s, ir_load_s, dmem_req_s, reg_wren_s, pc_en_s, retire_s;
   logic [1:0]       pc_sel_s;
   logic             unused_instr_s;

   assign opcode_s       = instr[31:26];
   assign funct_s        = instr[5:0];
   assign unused_instr_s = ^instr[25:6];
   assign branch_taken_s = is_beq_s ? alu_zero : !alu_zero;

   // Classify the IR contents and pick the ALU operation.
   always_comb begin
      legal_s = 1'b0; is_ralu_s = 1'b0; is_jr_s = 1'b0; is_j_s = 1'b0;
      is_branch_s = 1'b0; is_beq_s = 1'b0; is_load_s = 1'b0; is_store_s = 1'b0;
      is_lui_s = 1'b0; alu_op_s = ALU_AND; store_be_s = {BE_W{1'b0}};
      case (opcode_s)
         OP_RTYPE: begin
            legal_s   = 1'b1;
            is_ralu_s = 1'b1;
            case (funct_s)
               FN_SLL:  alu_op_s = ALU_SLL;
               FN_SRL:  alu_op_s = ALU_SRL;
               FN_SRA:  alu_op_s = ALU_SRA;
               FN_ADD:  alu_op_s = ALU_ADD;
               FN_ADDU: alu_op_s = ALU_ADDU;
               FN_SUB:  alu_op_s = ALU_SUB;
               FN_SUBU: alu_op_s = ALU_SUBU;
               FN_AND:  alu_op_s = ALU_AND;
               FN_OR:   alu_op_s = ALU_OR;
               FN_XOR:  alu_op_s = ALU_XOR;
               FN_NOR:  alu_op_s = ALU_NOR;
               FN_SLT:  alu_op_s = ALU_SLT;
               FN_JR:   begin is_ralu_s = 1'b0; is_jr_s = 1'b1; end
               default: begin legal_s = 1'b0; is_ralu_s = 1'b0; end
            endcase
         end
         OP_ADDI:  begin legal_s = 1'b1; alu_op_s = ALU_ADD;  end
         OP_ADDIU: begin legal_s = 1'b1; alu_op_s = ALU_ADDU; end
         OP_SLTI:  begin legal_s = 1'b1; alu_op_s = ALU_SLT;  end
         OP_ANDI:  begin legal_s = 1'b1; alu_op_s = ALU_AND;  end
         OP_ORI:   begin legal_s = 1'b1; alu_op_s = ALU_OR;   end
         OP_LUI:   begin legal_s = 1'b1; is_lui_s = 1'b1;     end
         OP_LW:    begin legal_s = 1'b1; is_load_s = 1'b1; alu_op_s = ALU_ADDU; end
         OP_SB:    begin legal_s = 1'b1; is_store_s = 1'b1; alu_op_s = ALU_ADDU; store_be_s = BE_BYTE_C; end
         OP_SH:    begin legal_s = 1'b1; is_store_s = 1'b1; alu_op_s = ALU_ADDU; store_be_s = BE_HALF_C; end
         OP_SW:    begin legal_s = 1'b1; is_store_s = 1'b1; alu_op_s = ALU_ADDU; store_be_s = BE_WORD_C; end
         OP_BEQ:   begin legal_s = 1'b1; is_branch_s = 1'b1; is_beq_s = 1'b1; alu_op_s = ALU_SUBU; end
         OP_BNE:   begin legal_s = 1'b1; is_branch_s = 1'b1; alu_op_s = ALU_SUBU; end
         OP_J:     begin legal_s = 1'b1; is_j_s = 1'b1; end
         default:  legal_s = 1'b0;
      endcase
   end

   // Sequencing: next state, ack-wait counter, trap flags and per-state strobes.
   always_comb begin
      state_nxt_s = state_r; cnt_nxt_s = {CNT_W{1'b0}};
      illegal_nxt_s = illegal_r; bus_err_nxt_s = bus_err_r;
      imem_req_s = 1'b0; ir_load_s = 1'b0; dmem_req_s = 1'b0; dmem_be_s = {BE_W{1'b0}};
      reg_wren_s = 1'b0; pc_en_s = 1'b0; pc_sel_s = 2'b00; retire_s = 1'b0;
      case (state_r)
         ST_FETCH: begin
            imem_req_s = 1'b1;
            if (imem_ack) begin
               ir_load_s = 1'b1; pc_en_s = 1'b1; state_nxt_s = ST_DECODE;
            end else if (TIMEOUT_EN_C && (cnt_r == TIMEOUT_C)) begin
               state_nxt_s = ST_TRAP; bus_err_nxt_s = 1'b1;
            end else begin
               cnt_nxt_s = cnt_r + CNT_ONE_C;
            end
         end
         ST_DECODE: begin
            if (!legal_s) begin
               state_nxt_s = ST_TRAP; illegal_nxt_s = 1'b1;
            end else if (is_j_s) begin
               pc_en_s = 1'b1; pc_sel_s = 2'b01; retire_s = 1'b1; state_nxt_s = ST_FETCH;
            end else if (is_jr_s) begin
               pc_en_s = 1'b1; pc_sel_s = 2'b10; retire_s = 1'b1; state_nxt_s = ST_FETCH;
            end else begin
               state_nxt_s = ST_EXEC;
            end
         end
         ST_EXEC: begin
            if (is_branch_s) begin
               pc_en_s = branch_taken_s; pc_sel_s = branch_taken_s ? 2'b11 : 2'b00;
               retire_s = 1'b1; state_nxt_s = ST_FETCH;
            end else if (is_load_s || is_store_s) begin
               state_nxt_s = ST_MEM;
            end else begin
               state_nxt_s = ST_WB;
            end
         end
         ST_MEM: begin
            dmem_req_s = 1'b1;
            dmem_be_s  = store_be_s;
            if (dmem_ack) begin
               retire_s    = is_store_s;
               state_nxt_s = is_store_s ? ST_FETCH : ST_WB;
            end else if (TIMEOUT_EN_C && (cnt_r == TIMEOUT_C)) begin
               state_nxt_s = ST_TRAP; bus_err_nxt_s = 1'b1;
            end else begin
               cnt_nxt_s = cnt_r + CNT_ONE_C;
            end
         end
         ST_WB: begin
            reg_wren_s = 1'b1; retire_s = 1'b1; state_nxt_s = ST_FETCH;
         end
         ST_TRAP: state_nxt_s = ST_TRAP;
         default: state_nxt_s = ST_FETCH;
      endcase
   end

   // Datapath steering is only meaningful once the IR holds the current instruction.
   assign steer_s = (state_r == ST_DECODE) || (state_r == ST_EXEC) ||
                    (state_r == ST_MEM)    || (state_r == ST_WB);

   assign imem_req    = !rst && imem_req_s;
   assign ir_load     = !rst && ir_load_s;
   assign dmem_req    = !rst && dmem_req_s;
   assign dmem_be     = rst ? {BE_W{1'b0}} : dmem_be_s;
   assign reg_wren    = !rst && reg_wren_s;
   assign pc_en       = !rst && pc_en_s;
   assign pc_sel      = rst ? 2'b00 : pc_sel_s;
   assign retire      = !rst && retire_s;
   assign dmux_sel    = !rst && steer_s && !(is_load_s || is_lui_s);
   assign rmux_sel    = !rst && steer_s && is_ralu_s;
   assign alu_src_sel = !rst && steer_s && (is_ralu_s || is_branch_s);
   assign alu_ctrl    = (!rst && steer_s) ? alu_op_s : 4'b0000;
   assign illegal     = illegal_r;
   assign bus_err     = bus_err_r;

   // State, wait counter and sticky trap flags.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r   <= ST_FETCH;
         cnt_r     <= {CNT_W{1'b0}};
         illegal_r <= 1'b0;
         bus_err_r <= 1'b0;
      end else begin
         state_r   <= state_nxt_s;
         cnt_r     <= cnt_nxt_s;
         illegal_r <= illegal_nxt_s;
         bus_err_r <= bus_err_nxt_s;
      end
   end
endmodule

// File: tb/tb_mc_control_unit.sv
// Bench for mc_control_unit: directed scenarios then random instructions, each checked
// cycle by cycle against an instruction-table reference model.
module tb_mc_control_unit;
   localparam int BE_W = 4;
   localparam int TO   = 4;

   typedef enum logic [3:0] {K_RALU, K_IALU, K_LUI, K_LOAD, K_STORE, K_BR, K_J, K_JR} kind_t;
   typedef struct packed {
      logic [5:0] op;
      logic [5:0] fn;
      logic       rfmt;
      kind_t      k;
      logic [3:0] alu;
      logic [3:0] be;
   } ent_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [31:0] instr = 32'h0;
   logic alu_zero = 1'b0, imem_ack = 1'b0, dmem_ack = 1'b0;
   logic imem_req, ir_load, dmem_req, reg_wren, dmux_sel, rmux_sel, alu_src_sel;
   logic pc_en, retire, illegal, bus_err;
   logic [BE_W-1:0] dmem_be;
   logic [3:0] alu_ctrl;
   logic [1:0] pc_sel;

   int n_chk = 0;
   int n_fail = 0;
   ent_t isa[$];

   mc_control_unit #(.BE_W(BE_W), .MEM_TIMEOUT(TO), .CNT_W(8)) dut (
      .clk(clk), .rst(rst), .instr(instr), .alu_zero(alu_zero), .imem_ack(imem_ack),
      .dmem_ack(dmem_ack), .imem_req(imem_req), .ir_load(ir_load), .dmem_req(dmem_req),
      .dmem_be(dmem_be), .reg_wren(reg_wren), .dmux_sel(dmux_sel), .rmux_sel(rmux_sel),
      .alu_src_sel(alu_src_sel), .alu_ctrl(alu_ctrl), .pc_en(pc_en), .pc_sel(pc_sel),
      .retire(retire), .illegal(illegal), .bus_err(bus_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic bit lookup(input logic [31:0] iw, output ent_t e);
      lookup = 1'b0;
      e = isa[0];
      foreach (isa[n])
         if (isa[n].op == iw[31:26] && (!isa[n].rfmt || isa[n].fn == iw[5:0])) begin
            e = isa[n];
            lookup = 1'b1;
         end
   endfunction

   function automatic logic [31:0] make_word(input ent_t e);
      logic [31:0] r;
      r = $urandom();
      make_word = {e.op, r[25:6], e.rfmt ? e.fn : r[5:0]};
   endfunction

   // Cycles from the first fetch cycle to the retire cycle with zero-wait memory.
   function automatic int base_lat(input kind_t k);
      case (k)
         K_J, K_JR: base_lat = 2;
         K_BR:      base_lat = 3;
         K_LOAD:    base_lat = 5;
         default:   base_lat = 4;
      endcase
   endfunction

   task automatic do_reset();
      rst = 1'b1; imem_ack = 1'b1; dmem_ack = 1'b1;
      @(negedge clk);
      chk("rst_imem_req", imem_req, 1'b0);
      chk("rst_ir_load", ir_load, 1'b0);
      chk("rst_dmem_req", dmem_req, 1'b0);
      chk("rst_pc_en", pc_en, 1'b0);
      chk("rst_retire", retire, 1'b0);
      @(posedge clk); #1;
      rst = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0; #1;
      chk("rst_illegal", illegal, 1'b0);
      chk("rst_bus_err", bus_err, 1'b0);
      chk("rst_fetch_req", imem_req, 1'b1);
      chk("rst_reg_wren", reg_wren, 1'b0);
   endtask

   task automatic expect_bus_trap();
      for (int k = 0; k < 3; k++) begin
         imem_ack = 1'($urandom_range(0, 1));
         dmem_ack = 1'($urandom_range(0, 1));
         @(negedge clk);
         chk("trap_bus_err", bus_err, 1'b1);
         chk("trap_imem_req", imem_req, 1'b0);
         chk("trap_dmem_req", dmem_req, 1'b0);
         chk("trap_retire", retire, 1'b0);
         chk("trap_no_illegal", illegal, 1'b0);
         @(posedge clk); #1;
      end
      do_reset();
   endtask

   // One instruction from its first fetch cycle to retire (or trap); entered and left at posedge+1.
   task automatic run_instr(input logic [31:0] iw, input int fw, input int mw, input bit z, input int rst_mem);
      ent_t e;
      bit ok, mem_op, taken;
      int cyc;
      ok = lookup(iw, e);
      mem_op = ok && (e.k == K_LOAD || e.k == K_STORE);
      cyc = 0;
      for (int k = 0; k < fw && k <= TO; k++) begin
         imem_ack = 1'b0;
         @(negedge clk); cyc++;
         chk("fetch_wait_req", imem_req, 1'b1);
         chk("fetch_wait_irload", ir_load, 1'b0);
         @(posedge clk); #1;
      end
      if (fw > TO) begin
         expect_bus_trap();
         return;
      end
      imem_ack = 1'b1;
      @(negedge clk); cyc++;
      chk("fetch_ack_req", imem_req, 1'b1);
      chk("fetch_irload", ir_load, 1'b1);
      chk("fetch_pc_en", pc_en, 1'b1);
      chk("fetch_pc_sel", pc_sel, 2'b00);
      @(posedge clk); #1;
      imem_ack = 1'b0; instr = iw; alu_zero = z;
      @(negedge clk); cyc++;
      chk("decode_imem_req", imem_req, 1'b0);
      if (!ok) begin
         chk("illegal_pc_en", pc_en, 1'b0);
         chk("illegal_retire", retire, 1'b0);
         @(posedge clk); #1;
         for (int k = 0; k < 3; k++) begin
            imem_ack = 1'($urandom_range(0, 1));
            @(negedge clk);
            chk("trap_illegal", illegal, 1'b1);
            chk("trap_illegal_req", imem_req, 1'b0);
            chk("trap_illegal_wren", reg_wren, 1'b0);
            chk("trap_illegal_bus_err", bus_err, 1'b0);
            @(posedge clk); #1;
         end
         do_reset();
         return;
      end
      if (e.k == K_J || e.k == K_JR) begin
         chk("jump_pc_en", pc_en, 1'b1);
         chk("jump_pc_sel", pc_sel, (e.k == K_J) ? 2'b01 : 2'b10);
         chk("jump_retire", retire, 1'b1);
         chk("jump_latency", cyc, base_lat(e.k) + fw);
         @(posedge clk); #1;
         return;
      end
      chk("decode_pc_en", pc_en, 1'b0);
      chk("decode_retire", retire, 1'b0);
      @(posedge clk); #1;
      @(negedge clk); cyc++;
      if (e.k != K_LUI) chk("exec_alu_ctrl", alu_ctrl, e.alu);
      chk("exec_alu_src", alu_src_sel, (e.rfmt || e.k == K_BR));
      if (e.k == K_BR) begin
         taken = (e.op == 6'h04) ? z : !z;
         chk("branch_pc_en", pc_en, taken);
         if (taken) chk("branch_pc_sel", pc_sel, 2'b11);
         chk("branch_retire", retire, 1'b1);
         chk("branch_latency", cyc, base_lat(e.k) + fw);
         @(posedge clk); #1;
         return;
      end
      chk("exec_retire", retire, 1'b0);
      chk("exec_dmem_req", dmem_req, 1'b0);
      @(posedge clk); #1;
      if (mem_op) begin
         for (int k = 0; k < mw && k <= TO; k++) begin
            dmem_ack = 1'b0;
            if (k == rst_mem) begin
               rst = 1'b1; dmem_ack = 1'b1;
               @(negedge clk);
               chk("rst_mem_dmem_req", dmem_req, 1'b0);
               chk("rst_mem_reg_wren", reg_wren, 1'b0);
               @(posedge clk); #1;
               rst = 1'b0; dmem_ack = 1'b0; #1;
               chk("rst_mem_fetch_req", imem_req, 1'b1);
               chk("rst_mem_dmem_idle", dmem_req, 1'b0);
               chk("rst_mem_no_wren", reg_wren, 1'b0);
               return;
            end
            @(negedge clk); cyc++;
            chk("mem_wait_req", dmem_req, 1'b1);
            chk("mem_wait_be", dmem_be, (e.k == K_STORE) ? e.be : 4'h0);
            chk("mem_wait_retire", retire, 1'b0);
            @(posedge clk); #1;
         end
         if (mw > TO) begin
            expect_bus_trap();
            return;
         end
         dmem_ack = 1'b1;
         @(negedge clk); cyc++;
         chk("mem_ack_req", dmem_req, 1'b1);
         chk("mem_ack_be", dmem_be, (e.k == K_STORE) ? e.be : 4'h0);
         chk("mem_ack_retire", retire, (e.k == K_STORE));
         if (e.k == K_STORE) chk("store_latency", cyc, base_lat(e.k) + fw + mw);
         @(posedge clk); #1;
         dmem_ack = 1'b0;
         if (e.k == K_STORE) return;
      end
      @(negedge clk); cyc++;
      chk("wb_reg_wren", reg_wren, 1'b1);
      chk("wb_rmux_sel", rmux_sel, e.rfmt);
      chk("wb_dmux_sel", dmux_sel, !(e.k == K_LOAD || e.k == K_LUI));
      chk("wb_retire", retire, 1'b1);
      if (e.k != K_LUI) chk("wb_alu_ctrl", alu_ctrl, e.alu);
      chk("wb_latency", cyc, base_lat(e.k) + fw + (mem_op ? mw : 0));
      chk("wb_bus_err", bus_err, 1'b0);
      @(posedge clk); #1;
   endtask

   initial begin
      isa.push_back({6'h00, 6'h00, 1'b1, K_RALU, 4'b1001, 4'h0});
      isa.push_back({6'h00, 6'h02, 1'b1, K_RALU, 4'b1010, 4'h0});
      isa.push_back({6'h00, 6'h03, 1'b1, K_RALU, 4'b1011, 4'h0});
      isa.push_back({6'h00, 6'h08, 1'b1, K_JR,   4'b0000, 4'h0});
      isa.push_back({6'h00, 6'h20, 1'b1, K_RALU, 4'b0101, 4'h0});
      isa.push_back({6'h00, 6'h21, 1'b1, K_RALU, 4'b0100, 4'h0});
      isa.push_back({6'h00, 6'h22, 1'b1, K_RALU, 4'b0111, 4'h0});
      isa.push_back({6'h00, 6'h23, 1'b1, K_RALU, 4'b0110, 4'h0});
      isa.push_back({6'h00, 6'h24, 1'b1, K_RALU, 4'b0000, 4'h0});
      isa.push_back({6'h00, 6'h25, 1'b1, K_RALU, 4'b0001, 4'h0});
      isa.push_back({6'h00, 6'h26, 1'b1, K_RALU, 4'b0010, 4'h0});
      isa.push_back({6'h00, 6'h27, 1'b1, K_RALU, 4'b0011, 4'h0});
      isa.push_back({6'h00, 6'h2A, 1'b1, K_RALU, 4'b1000, 4'h0});
      isa.push_back({6'h08, 6'h00, 1'b0, K_IALU, 4'b0101, 4'h0});
      isa.push_back({6'h09, 6'h00, 1'b0, K_IALU, 4'b0100, 4'h0});
      isa.push_back({6'h0A, 6'h00, 1'b0, K_IALU, 4'b1000, 4'h0});
      isa.push_back({6'h0C, 6'h00, 1'b0, K_IALU, 4'b0000, 4'h0});
      isa.push_back({6'h0D, 6'h00, 1'b0, K_IALU, 4'b0001, 4'h0});
      isa.push_back({6'h0F, 6'h00, 1'b0, K_LUI,  4'b0000, 4'h0});
      isa.push_back({6'h23, 6'h00, 1'b0, K_LOAD, 4'b0100, 4'h0});
      isa.push_back({6'h28, 6'h00, 1'b0, K_STORE, 4'b0100, 4'h1});
      isa.push_back({6'h29, 6'h00, 1'b0, K_STORE, 4'b0100, 4'h3});
      isa.push_back({6'h2B, 6'h00, 1'b0, K_STORE, 4'b0100, 4'hF});
      isa.push_back({6'h04, 6'h00, 1'b0, K_BR,   4'b0110, 4'h0});
      isa.push_back({6'h05, 6'h00, 1'b0, K_BR,   4'b0110, 4'h0});
      isa.push_back({6'h02, 6'h00, 1'b0, K_J,    4'b0000, 4'h0});

      do_reset();
      // ADDU $3,$1,$2 with an immediate fetch ack
      run_instr({6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h21}, 0, 0, 1'b0, -1);
      // SB, SH, SW each waiting three cycles for the data ack
      run_instr({6'h28, 5'd4, 5'd5, 16'h0010}, 0, 3, 1'b0, -1);
      run_instr({6'h29, 5'd4, 5'd5, 16'h0012}, 0, 3, 1'b0, -1);
      run_instr({6'h2B, 5'd4, 5'd5, 16'h0014}, 0, 3, 1'b0, -1);
      // BEQ taken and not taken, BNE both ways
      run_instr({6'h04, 5'd1, 5'd2, 16'hFFFC}, 0, 0, 1'b1, -1);
      run_instr({6'h04, 5'd1, 5'd2, 16'hFFFC}, 0, 0, 1'b0, -1);
      run_instr({6'h05, 5'd1, 5'd2, 16'h0008}, 1, 0, 1'b0, -1);
      run_instr({6'h05, 5'd1, 5'd2, 16'h0008}, 0, 0, 1'b1, -1);
      // undefined opcode and undefined funct
      run_instr(32'hFC00_0000, 0, 0, 1'b0, -1);
      run_instr({6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h3F}, 0, 0, 1'b0, -1);
      // fetch ack never arrives, then arrives on the last allowed cycle
      run_instr({6'h08, 5'd1, 5'd2, 16'h1234}, TO + 1, 0, 1'b0, -1);
      run_instr({6'h08, 5'd1, 5'd2, 16'h1234}, TO, 0, 1'b0, -1);
      // data ack timeout on a load, data ack on the last allowed cycle
      run_instr({6'h23, 5'd1, 5'd2, 16'h0004}, 0, TO + 1, 1'b0, -1);
      run_instr({6'h23, 5'd1, 5'd2, 16'h0004}, 0, TO, 1'b0, -1);
      // reset during the MEM wait of a load
      run_instr({6'h23, 5'd1, 5'd2, 16'h0004}, 0, 3, 1'b0, 1);
      // J, JR, LUI, zero-wait LW
      run_instr({6'h02, 26'h0000_100}, 0, 0, 1'b0, -1);
      run_instr({6'h00, 5'd31, 15'h0, 6'h08}, 2, 0, 1'b0, -1);
      run_instr({6'h0F, 5'd0, 5'd7, 16'hABCD}, 0, 0, 1'b0, -1);
      run_instr({6'h23, 5'd1, 5'd2, 16'h0008}, 0, 0, 1'b0, -1);

      for (int n = 0; n < 80; n++) begin
         logic [31:0] w;
         int pick;
         if ($urandom_range(0, 7) == 0) begin
            w = $urandom();
         end else begin
            pick = int'($urandom_range(0, isa.size() - 1));
            w = make_word(isa[pick]);
         end
         run_instr(w, int'($urandom_range(0, TO)), int'($urandom_range(0, TO)),
                   1'($urandom_range(0, 1)), -1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
